// File: rtl/board_memory_pkg.sv
// Shared board constants: piece codes, board geometry and the board_memory FSM states.
// The control FSM and the VGA renderer import the same definitions.
package board_memory_pkg;

  localparam int BOARD_W_DEF = 9;
  localparam int BOARD_H_DEF = 10;
  localparam int PIECE_W_DEF = 4;
  localparam int BOARD_CELLS = BOARD_W_DEF * BOARD_H_DEF;
  localparam int IDX_W       = 8;

  localparam logic [PIECE_W_DEF-1:0] PIECE_EMPTY    = 4'd0;
  localparam logic [PIECE_W_DEF-1:0] PIECE_GENERAL  = 4'd1;
  localparam logic [PIECE_W_DEF-1:0] PIECE_ADVISOR  = 4'd2;
  localparam logic [PIECE_W_DEF-1:0] PIECE_ELEPHANT = 4'd3;
  localparam logic [PIECE_W_DEF-1:0] PIECE_HORSE    = 4'd4;
  localparam logic [PIECE_W_DEF-1:0] PIECE_CHARIOT  = 4'd5;
  localparam logic [PIECE_W_DEF-1:0] PIECE_CANNON   = 4'd6;
  localparam logic [PIECE_W_DEF-1:0] PIECE_SOLDIER  = 4'd7;
  localparam logic [PIECE_W_DEF-1:0] OWNER_BLACK    = 4'b1000;

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_IDLE  = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_CLEAR = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Ownership is ignored: losing either general ends the game.
  function automatic logic isGeneral(input logic [PIECE_W_DEF-1:0] piece);
    return piece[2:0] == PIECE_GENERAL[2:0];
  endfunction

endpackage

// File: rtl/board_memory_init_rom.sv
// Combinational initial layout: cell index (y*9+x) to the piece standing there at game start.
// Only the red half is tabulated; black ranks are mirrored (y' = 9-y) with the owner bit set.
module board_init_rom
  import board_memory_pkg::*;
#(
  parameter int INDEX_W = 7
) (
  input  logic [INDEX_W-1:0]     index_i,
  output logic [PIECE_W_DEF-1:0] piece_o
);

  logic [3:0] rank;
  logic [3:0] file;
  logic [3:0] redRank;
  logic       black;

  always_comb begin
    rank    = 4'(index_i / INDEX_W'(BOARD_W_DEF));
    file    = 4'(index_i % INDEX_W'(BOARD_W_DEF));
    black   = (rank >= 4'd5);
    redRank = black ? (4'd9 - rank) : rank;
    piece_o = PIECE_EMPTY;
    if (index_i < INDEX_W'(BOARD_CELLS)) begin
      case (redRank)
        4'd0: begin
          case (file)
            4'd0, 4'd8: piece_o = PIECE_CHARIOT;
            4'd1, 4'd7: piece_o = PIECE_HORSE;
            4'd2, 4'd6: piece_o = PIECE_ELEPHANT;
            4'd3, 4'd5: piece_o = PIECE_ADVISOR;
            4'd4:       piece_o = PIECE_GENERAL;
            default:    piece_o = PIECE_EMPTY;
          endcase
        end
        4'd2: begin
          if (file == 4'd1 || file == 4'd7) piece_o = PIECE_CANNON;
        end
        4'd3: begin
          if (!file[0]) piece_o = PIECE_SOLDIER;
        end
        default: piece_o = PIECE_EMPTY;
      endcase
      if (black && piece_o != PIECE_EMPTY) piece_o = piece_o | OWNER_BLACK;
    end
  end

endmodule

// File: rtl/board_memory.sv
// Board-state store: holds the piece map, answers the select-box lookup and executes
// committed moves as a read / write-destination / clear-source sequence.
module board_memory
  import board_memory_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF,
  parameter int PIECE_W = PIECE_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               reload,
  input  logic [3:0]         query_x,
  input  logic [3:0]         query_y,
  output logic [PIECE_W-1:0] query_piece,
  input  logic               commit,
  input  logic [3:0]         src_x,
  input  logic [3:0]         src_y,
  input  logic [3:0]         dst_x,
  input  logic [3:0]         dst_y,
  output logic               busy,
  output logic               done,
  output logic               move_err,
  output logic [PIECE_W-1:0] captured,
  output logic               general_captured
);

  localparam int CELLS = BOARD_W * BOARD_H;
  localparam int CNT_W = $clog2(CELLS);

  function automatic logic [IDX_W-1:0] toIndex(input logic [3:0] x, input logic [3:0] y);
    return IDX_W'(y) * IDX_W'(BOARD_W) + IDX_W'(x);
  endfunction

  function automatic logic onBoard(input logic [3:0] x, input logic [3:0] y,
                                   input logic [IDX_W-1:0] idx);
    return (x < 4'(BOARD_W)) && (y < 4'(BOARD_H)) && (idx < IDX_W'(CELLS));
  endfunction

  logic [PIECE_W-1:0] mem [CELLS];

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         srcX_q, srcY_q, dstX_q, dstY_q;
  logic [PIECE_W-1:0] srcPiece_q, dstPiece_q;
  logic               err_q;
  logic [PIECE_W-1:0] queryPiece_q, captured_q;
  logic               done_q, moveErr_q, general_q;

  logic [IDX_W-1:0]   qIdx, srcIdx, dstIdx;
  logic               qOk, srcOk, dstOk;
  logic [PIECE_W-1:0] srcRd, dstRd;
  logic               readErr;
  logic [PIECE_W-1:0] romPiece;

  logic               wrEn_d;
  logic [CNT_W-1:0]   wrAddr_d;
  logic [PIECE_W-1:0] wrData_d;

  board_init_rom #(
    .INDEX_W (CNT_W)
  ) u_rom (
    .index_i (cnt_q),
    .piece_o (romPiece)
  );

  assign qIdx   = toIndex(query_x, query_y);
  assign srcIdx = toIndex(srcX_q, srcY_q);
  assign dstIdx = toIndex(dstX_q, dstY_q);
  assign qOk    = onBoard(query_x, query_y, qIdx);
  assign srcOk  = onBoard(srcX_q, srcY_q, srcIdx);
  assign dstOk  = onBoard(dstX_q, dstY_q, dstIdx);
  assign srcRd  = srcOk ? mem[srcIdx[CNT_W-1:0]] : '0;
  assign dstRd  = dstOk ? mem[dstIdx[CNT_W-1:0]] : '0;

  assign readErr = !srcOk || !dstOk ||
                   ((srcX_q == dstX_q) && (srcY_q == dstY_q)) ||
                   (srcRd == '0);

  // Single write port shared by the layout load and the two move phases.
  always_comb begin
    wrEn_d   = 1'b0;
    wrAddr_d = '0;
    wrData_d = '0;
    if (!reload) begin
      case (state_q)
        S_LOAD: begin
          wrEn_d   = 1'b1;
          wrAddr_d = cnt_q;
          wrData_d = romPiece;
        end
        S_WRITE: begin
          wrEn_d   = 1'b1;
          wrAddr_d = dstIdx[CNT_W-1:0];
          wrData_d = srcPiece_q;
        end
        S_CLEAR: begin
          wrEn_d   = 1'b1;
          wrAddr_d = srcIdx[CNT_W-1:0];
          wrData_d = '0;
        end
        default: wrEn_d = 1'b0;
      endcase
    end
  end

  // Contents are rebuilt by S_LOAD after reset, so the array itself carries no reset.
  always_ff @(posedge clk) begin
    if (wrEn_d) mem[wrAddr_d] <= wrData_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_LOAD;
      cnt_q        <= '0;
      srcX_q       <= '0;
      srcY_q       <= '0;
      dstX_q       <= '0;
      dstY_q       <= '0;
      srcPiece_q   <= '0;
      dstPiece_q   <= '0;
      err_q        <= 1'b0;
      queryPiece_q <= '0;
      captured_q   <= '0;
      done_q       <= 1'b0;
      moveErr_q    <= 1'b0;
      general_q    <= 1'b0;
    end else begin
      queryPiece_q <= qOk ? mem[qIdx[CNT_W-1:0]] : '0;
      done_q       <= 1'b0;
      if (reload) begin
        state_q <= S_LOAD;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_LOAD: begin
            if (cnt_q == CNT_W'(CELLS - 1)) state_q <= S_IDLE;
            else                            cnt_q   <= cnt_q + CNT_W'(1);
          end
          S_IDLE: begin
            if (commit) begin
              srcX_q  <= src_x;
              srcY_q  <= src_y;
              dstX_q  <= dst_x;
              dstY_q  <= dst_y;
              state_q <= S_READ;
            end
          end
          S_READ: begin
            srcPiece_q <= srcRd;
            dstPiece_q <= dstRd;
            err_q      <= readErr;
            state_q    <= readErr ? S_DONE : S_WRITE;
          end
          S_WRITE: state_q <= S_CLEAR;
          S_CLEAR: state_q <= S_DONE;
          S_DONE: begin
            done_q     <= 1'b1;
            moveErr_q  <= err_q;
            captured_q <= err_q ? '0 : dstPiece_q;
            general_q  <= !err_q && isGeneral(dstPiece_q);
            state_q    <= S_IDLE;
          end
          default: state_q <= S_LOAD;
        endcase
      end
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign done             = done_q;
  assign move_err         = moveErr_q;
  assign captured         = captured_q;
  assign general_captured = general_q;
  assign query_piece      = queryPiece_q;

endmodule

// File: tb/tb_board_memory.sv
// Scoreboard bench for board_memory: stimulus pushes hand-computed expectations,
// a negedge monitor pops them when a query result or a done pulse appears.
module tb_board_memory;

  logic       clk = 1'b0;
  logic       reset, reload, commit;
  logic [3:0] query_x, query_y, src_x, src_y, dst_x, dst_y;
  logic [3:0] query_piece, captured;
  logic       busy, done, move_err, general_captured;

  typedef struct {
    logic       err;
    logic [3:0] cap;
    logic       gen;
    int         due;
  } moveExp_t;

  typedef struct {
    string      name;
    logic [3:0] exp;
  } queryExp_t;

  moveExp_t  moveQ[$];
  queryExp_t queryQ[$];
  int        tests = 0;
  int        fails = 0;
  int        cycle = 0;
  logic      queryStrobe = 1'b0;
  logic      qLive = 1'b0;

  board_memory dut (
    .clk              (clk),
    .reset            (reset),
    .reload           (reload),
    .query_x          (query_x),
    .query_y          (query_y),
    .query_piece      (query_piece),
    .commit           (commit),
    .src_x            (src_x),
    .src_y            (src_y),
    .dst_x            (dst_x),
    .dst_y            (dst_y),
    .busy             (busy),
    .done             (done),
    .move_err         (move_err),
    .captured         (captured),
    .general_captured (general_captured)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cycle <= cycle + 1;
    qLive <= queryStrobe;
  end

  // Monitor: a strobed query is answered one edge later; every done must match a queued move.
  always @(negedge clk) begin
    if (qLive && queryQ.size() != 0) begin
      queryExp_t q;
      q = queryQ.pop_front();
      checkOutput(q.name, 32'(query_piece), 32'(q.exp));
    end
    if (done) begin
      if (moveQ.size() == 0) begin
        checkOutput("unexpected done", 32'(done), 32'd0);
      end else begin
        moveExp_t e;
        e = moveQ.pop_front();
        checkOutput("done latency", cycle, e.due);
        checkOutput("move_err", 32'(move_err), 32'(e.err));
        checkOutput("captured", 32'(captured), 32'(e.cap));
        checkOutput("general_captured", 32'(general_captured), 32'(e.gen));
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] sx, input logic [3:0] sy,
                               input logic [3:0] dx, input logic [3:0] dy,
                               input bit expectDone, input logic expErr,
                               input logic [3:0] expCap, input logic expGen);
    moveExp_t e;
    @(negedge clk);
    src_x  = sx;
    src_y  = sy;
    dst_x  = dx;
    dst_y  = dy;
    commit = 1'b1;
    if (expectDone) begin
      e.err = expErr;
      e.cap = expCap;
      e.gen = expGen;
      e.due = cycle + 1 + (expErr ? 2 : 4);
      moveQ.push_back(e);
    end
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    while (moveQ.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    checkOutput("done timeout", moveQ.size(), 0);
    @(negedge clk);
  endtask

  task automatic doQuery(input string name, input logic [3:0] x, input logic [3:0] y,
                         input logic [3:0] exp);
    queryExp_t q;
    @(negedge clk);
    query_x     = x;
    query_y     = y;
    queryStrobe = 1'b1;
    q.name      = name;
    q.exp       = exp;
    queryQ.push_back(q);
    @(negedge clk);
    queryStrobe = 1'b0;
  endtask

  // Counts negedges until busy falls; optionally pokes a commit mid-load, which must be ignored.
  task automatic waitLoad(input bit poke);
    int n = 0;
    bit fell = 0;
    while (n < 200 && !fell) begin
      @(negedge clk);
      n++;
      if (poke && n == 10) begin
        src_x  = 4'd1;
        src_y  = 4'd0;
        dst_x  = 4'd2;
        dst_y  = 4'd2;
        commit = 1'b1;
      end
      if (poke && n == 11) commit = 1'b0;
      if (!busy) fell = 1;
    end
    checkOutput("load cycles", n, 90);
  endtask

  task automatic checkInitialLayout();
    doQuery("init (4,0)", 4'd4, 4'd0, 4'h1);
    doQuery("init (4,9)", 4'd4, 4'd9, 4'h9);
    doQuery("init (1,2)", 4'd1, 4'd2, 4'h6);
    doQuery("init (4,4)", 4'd4, 4'd4, 4'h0);
    doQuery("init (0,0)", 4'd0, 4'd0, 4'h5);
    doQuery("init (0,9)", 4'd0, 4'd9, 4'hD);
    doQuery("init (0,3)", 4'd0, 4'd3, 4'h7);
    doQuery("init (7,7)", 4'd7, 4'd7, 4'hE);
    doQuery("init (1,5)", 4'd1, 4'd5, 4'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset   = 1'b1;
    reload  = 1'b0;
    commit  = 1'b0;
    query_x = '0;
    query_y = '0;
    src_x   = '0;
    src_y   = '0;
    dst_x   = '0;
    dst_y   = '0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd1);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset query_piece", 32'(query_piece), 32'd0);
    checkOutput("reset captured", 32'(captured), 32'd0);
    checkOutput("reset move_err", 32'(move_err), 32'd0);
    checkOutput("reset general", 32'(general_captured), 32'd0);

    reset = 1'b1;
    waitLoad(1'b1);
    checkInitialLayout();
    doQuery("out of range (9,0)", 4'd9, 4'd0, 4'h0);

    applyStimulus(4'd1, 4'd2, 4'd1, 4'd5, 1'b1, 1'b0, 4'h0, 1'b0);
    waitDone();
    doQuery("move1 dst (1,5)", 4'd1, 4'd5, 4'h6);
    doQuery("move1 src (1,2)", 4'd1, 4'd2, 4'h0);

    applyStimulus(4'd0, 4'd0, 4'd0, 4'd9, 1'b1, 1'b0, 4'hD, 1'b0);
    waitDone();
    doQuery("move2 dst (0,9)", 4'd0, 4'd9, 4'h5);
    doQuery("move2 src (0,0)", 4'd0, 4'd0, 4'h0);

    applyStimulus(4'd0, 4'd9, 4'd4, 4'd9, 1'b1, 1'b0, 4'h9, 1'b1);
    waitDone();
    doQuery("move3 dst (4,9)", 4'd4, 4'd9, 4'h5);
    doQuery("move3 src (0,9)", 4'd0, 4'd9, 4'h0);

    applyStimulus(4'd4, 4'd4, 4'd4, 4'd5, 1'b1, 1'b1, 4'h0, 1'b0);
    waitDone();
    applyStimulus(4'd0, 4'd3, 4'd0, 4'd3, 1'b1, 1'b1, 4'h0, 1'b0);
    waitDone();
    applyStimulus(4'd1, 4'd0, 4'd9, 4'd0, 1'b1, 1'b1, 4'h0, 1'b0);
    waitDone();
    applyStimulus(4'd2, 4'd10, 4'd2, 4'd0, 1'b1, 1'b1, 4'h0, 1'b0);
    waitDone();
    doQuery("err keep (4,5)", 4'd4, 4'd5, 4'h0);
    doQuery("err keep (0,3)", 4'd0, 4'd3, 4'h7);
    doQuery("err keep (1,0)", 4'd1, 4'd0, 4'h4);
    doQuery("err keep (2,0)", 4'd2, 4'd0, 4'h3);

    // The second commit lands while the first is in S_READ and must vanish.
    applyStimulus(4'd1, 4'd5, 4'd1, 4'd6, 1'b1, 1'b0, 4'h0, 1'b0);
    src_x  = 4'd3;
    src_y  = 4'd0;
    dst_x  = 4'd3;
    dst_y  = 4'd1;
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    waitDone();
    repeat (4) @(negedge clk);
    doQuery("busy drop (1,6)", 4'd1, 4'd6, 4'h6);
    doQuery("busy drop (1,5)", 4'd1, 4'd5, 4'h0);
    doQuery("busy drop (3,0)", 4'd3, 4'd0, 4'h2);
    doQuery("busy drop (3,1)", 4'd3, 4'd1, 4'h0);

    @(negedge clk);
    src_x  = 4'd4;
    src_y  = 4'd0;
    dst_x  = 4'd4;
    dst_y  = 4'd1;
    commit = 1'b1;
    reload = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    reload = 1'b0;
    waitLoad(1'b0);
    checkInitialLayout();

    applyStimulus(4'd0, 4'd3, 4'd0, 4'd4, 1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("mid-move reset busy", 32'(busy), 32'd1);
    checkOutput("mid-move reset done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("mid-move reset captured", 32'(captured), 32'd0);
    reset = 1'b1;
    waitLoad(1'b0);
    doQuery("after reset (0,3)", 4'd0, 4'd3, 4'h7);
    doQuery("after reset (0,4)", 4'd0, 4'd4, 4'h0);
    doQuery("after reset (4,9)", 4'd4, 4'd9, 4'h9);

    repeat (5) @(negedge clk);
    checkOutput("pending moves", moveQ.size(), 0);
    checkOutput("pending queries", queryQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/board_memory.md
Name: board_memory

Overview:
- Board-state store for the game datapath; sits directly upstream of the game control FSM.
- Holds the 9x10 piece map and answers the FSM's piece lookup at the select-box position (feeds selected_piece and validate_square).
- Executes the FSM's committed move (piece_x/y -> move_x/y) as a multi-cycle read-write-clear sequence.
- Reports captures, including general capture, which the FSM uses for its winning check.

Parameters:
- BOARD_W, 9, files (x range 0..BOARD_W-1)
- BOARD_H, 10, ranks (y range 0..BOARD_H-1); (0,0) is the red side, left-down corner
- PIECE_W, 4, piece code width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low; low forces the FSM to S_LOAD with the load counter at 0
- reload  in  1  single-cycle pulse; restarts the initial-layout load (new game)
- query_x, query_y  in  4  lookup coordinate (select-box position)
- query_piece  out  PIECE_W  piece at the lookup coordinate, registered
- commit  in  1  single-cycle pulse; execute move src -> dst
- src_x, src_y, dst_x, dst_y  in  4  move coordinates
- busy  out  1  high in any state other than S_IDLE
- done  out  1  one-cycle pulse when a commit finishes (success or error)
- move_err  out  1  valid with done; 1 = rejected, board unchanged
- captured  out  PIECE_W  piece previously at dst; valid with done, held until the next done
- general_captured  out  1  valid with done; captured[2:0]==3'd1

Behaviour:
- Piece encoding:
  - 0 = empty.
  - bit3 = owner (0 red, 1 black).
  - bits2:0 = type: 1 general, 2 advisor, 3 elephant, 4 horse, 5 chariot, 6 cannon, 7 soldier.
- Storage: BOARD_W*BOARD_H x PIECE_W array; index = y*BOARD_W + x; computed 8 bits wide, no truncation.
- Initial layout (red shown; black mirrors it at y' = 9-y with bit3 = 1):
  - y=0: x0..8 = chariot, horse, elephant, advisor, general, advisor, elephant, horse, chariot
  - y=2: cannons at x=1 and x=7
  - y=3: soldiers at x=0, 2, 4, 6, 8
  - every other cell = 0
- States: S_LOAD, S_IDLE, S_READ, S_WRITE, S_CLEAR, S_DONE.
- S_LOAD:
  - Writes one cell per cycle at index cnt, with cnt running 0..89.
  - Moves to S_IDLE after the cycle that writes cnt=89, so a load takes 90 cycles.
  - commit is ignored during S_LOAD.
- reload in any state: next state S_LOAD with cnt=0; an in-flight commit is abandoned with no done.
- reload has priority over commit in the same cycle.
- S_IDLE + commit: src/dst are registered; next state is S_READ.
- S_READ: latches mem[src] and mem[dst]; decides the error status.
- move_err = 1 when any of the following holds:
  - a coordinate is out of range (x >= BOARD_W or y >= BOARD_H);
  - src == dst;
  - mem[src] == 0.
- On error: S_READ -> S_DONE; no write occurs; captured = 0.
- Otherwise the sequence is S_WRITE (mem[dst] <= src piece), then S_CLEAR (mem[src] <= 0), then S_DONE.
- S_DONE: done=1 and captured is updated in the same cycle; next state is S_IDLE.
- Latency: done is high 4 cycles after the commit sample edge on success, and 2 cycles after on error.
- commit while busy is dropped, with no queueing.
- Capturing one's own piece is not checked here; rule legality belongs to the control FSM.
- Query port: query_piece <= mem[query] on every clock edge, with 1-cycle latency and in any state.
- Out-of-range query returns 0.
- A query of a cell being written returns the old value (read-before-write).
- Reset values:
  - state = S_LOAD, cnt = 0;
  - query_piece, captured, move_err, general_captured, done = 0;
  - busy = 1 (follows from S_LOAD).
- Memory contents are not reset asynchronously; they are rebuilt by S_LOAD.

Decomposition:
- Shared package header holds:
  - piece code constants (PIECE_EMPTY, PIECE_GENERAL..PIECE_SOLDIER, OWNER_BLACK bit);
  - BOARD_W/BOARD_H defaults;
  - state localparams.
- These constants are reused by the control FSM and the VGA renderer.
- One natural sub-module: board_init_rom, a combinational index (0..89) -> initial piece code, used in S_LOAD.

Test Plan:
- Load: release reset, wait for busy to fall (exactly 90 cycles).
  - query (4,0) -> 4'h1; query (4,9) -> 4'h9; query (1,2) -> 4'h6; query (4,4) -> 0.
- Simple move: commit src (1,2) dst (1,5).
  - done at +4 cycles, move_err=0, captured=0.
  - query (1,5) -> 4'h6; query (1,2) -> 0.
- Capture: commit src (0,0) dst (0,9).
  - captured = 4'hD, general_captured=0.
  - Then force (4,9) capture via a chariot path: captured = 4'h9, general_captured=1.
- Errors each give done at +2 cycles, move_err=1, and an unchanged board:
  - commit src (4,4) (empty);
  - commit src=dst=(0,0);
  - commit dst (9,0).
- Contention:
  - commit during S_LOAD -> no done;
  - second commit while busy -> dropped;
  - reload+commit in the same cycle -> S_LOAD, initial layout restored after 90 cycles.
- Reset mid-move: assert reset during S_WRITE -> busy=1, done never pulses; after 90 cycles the initial layout is restored.
